// File: rtl/tank_pkg.sv
// Shared types and constants for the tank turn sequencer.
// Build option TANK_ACCEL_EN (see tank_axis_adj) selects hold acceleration.
package tank_pkg;

  // Fixed encodings kept visible because game_state exports them raw.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_AIM      = 3'd1;
  localparam logic [2:0] ST_FIRE     = 3'd2;
  localparam logic [2:0] ST_FLIGHT   = 3'd3;
  localparam logic [2:0] ST_RESOLVE  = 3'd4;
  localparam logic [2:0] ST_SWAP     = 3'd5;
  localparam logic [2:0] ST_GAMEOVER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_AIM      = ST_AIM,
    S_FIRE     = ST_FIRE,
    S_FLIGHT   = ST_FLIGHT,
    S_RESOLVE  = ST_RESOLVE,
    S_SWAP     = ST_SWAP,
    S_GAMEOVER = ST_GAMEOVER
  } tank_state_t;

  localparam logic [7:0] PWR_INIT_DEF = 8'd128;
  localparam logic [7:0] ANG_INIT_DEF = 8'd64;

  localparam logic [2:0] STEP_SLOW = 3'd1;
  localparam logic [2:0] STEP_FAST = 3'd4;

endpackage

// File: rtl/tank_axis_adj.sv
// One saturating 8-bit inc/dec axis. With TANK_ACCEL_EN defined, a direction
// held for ACCEL_FRAMES consecutive enabled frames steps by 4 instead of 1.
module tank_axis_adj
  import tank_pkg::*;
#(
  parameter int unsigned ACCEL_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic [7:0] i_cur,
  output logic [7:0] o_nxt
);

  logic       w_one;
  logic [2:0] w_step;
  logic [8:0] w_sum;

  assign w_one = i_inc ^ i_dec;

`ifdef TANK_ACCEL_EN
  localparam logic [7:0] ACC_LIM = 8'(ACCEL_FRAMES);

  logic [7:0] r_hold;
  logic       r_dir;
  logic       w_cont;

  // r_hold counts frames already held before this one, saturating at ACC_LIM.
  assign w_cont = w_one && (r_hold != '0) && (r_dir == i_inc);
  assign w_step = (w_cont && (r_hold >= ACC_LIM)) ? STEP_FAST : STEP_SLOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_dir  <= 1'b0;
    end else if (i_clr) begin
      r_hold <= '0;
    end else if (i_en) begin
      if (!w_one) begin
        r_hold <= '0;
      end else begin
        r_dir <= i_inc;
        if (!w_cont)
          r_hold <= 8'd1;
        else if (r_hold < ACC_LIM)
          r_hold <= r_hold + 8'd1;
      end
    end
  end
`else
  logic w_unused;

  assign w_step   = STEP_SLOW;
  assign w_unused = ^{clk, rst_n, i_clr, i_en, 8'(ACCEL_FRAMES)};
`endif

  always_comb begin
    o_nxt = i_cur;
    w_sum = {1'b0, i_cur} + {6'b0, w_step};
    if (w_one) begin
      if (i_inc)
        o_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
      else
        o_nxt = (i_cur < {5'b0, w_step}) ? '0 : (i_cur - {5'b0, w_step});
    end
  end

endmodule

// File: rtl/tank_turn_ctrl.sv
// Turn/shot sequencer for the two-player tank game: aiming, fire strobe,
// flight wait, scoring and turn swap. TANK_ACCEL_EN enables hold acceleration.
module tank_turn_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 3,
  parameter int unsigned FLIGHT_TIMEOUT = 240,
  parameter logic [7:0]  PWR_INIT       = PWR_INIT_DEF,
  parameter logic [7:0]  ANG_INIT       = ANG_INIT_DEF,
  parameter int unsigned ACCEL_FRAMES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pad_present,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_a,
  input  logic       btn_start,
  input  logic       proj_done,
  input  logic [1:0] proj_hit,
  output logic [7:0] power,
  output logic [7:0] angle,
  output logic       active_player,
  output logic       fire,
  output logic [2:0] game_state,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       winner
);

  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [7:0] TO_LAST = 8'(FLIGHT_TIMEOUT - 1);

  tank_state_t r_state;
  logic        r_active;
  logic        r_fire;
  logic        r_winner;
  logic        r_start_q;
  logic        r_a_q;
  logic [7:0]  r_pwr [2];
  logic [7:0]  r_ang [2];
  logic [7:0]  r_flight;
  logic [1:0]  r_hits;
  logic [3:0]  r_score [2];

  logic       w_up, w_down, w_left, w_right, w_a, w_start;
  logic       w_start_edge, w_a_edge, w_in_aim, w_adj_en;
  logic       w_opp, w_opp_hit, w_self_hit;
  logic [3:0] w_act_inc, w_opp_inc;
  logic [7:0] w_pwr_nxt, w_ang_nxt;

  assign w_up    = btn_up    & pad_present;
  assign w_down  = btn_down  & pad_present;
  assign w_left  = btn_left  & pad_present;
  assign w_right = btn_right & pad_present;
  assign w_a     = btn_a     & pad_present;
  assign w_start = btn_start & pad_present;

  assign w_start_edge = frame_tick & w_start & ~r_start_q;
  assign w_a_edge     = frame_tick & w_a & ~r_a_q;
  assign w_in_aim     = (r_state == S_AIM);
  // The fire tick freezes the aim values, so adjustment is suppressed there.
  assign w_adj_en     = frame_tick & w_in_aim & ~w_a_edge;

  assign w_opp      = ~r_active;
  assign w_opp_hit  = r_hits[w_opp];
  assign w_self_hit = r_hits[r_active];
  assign w_act_inc  = r_score[r_active] + 4'd1;
  assign w_opp_inc  = r_score[w_opp] + 4'd1;

  tank_axis_adj #(.ACCEL_FRAMES(ACCEL_FRAMES)) u_pwr_adj (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adj_en),
    .i_clr (~w_in_aim),
    .i_inc (w_up),
    .i_dec (w_down),
    .i_cur (r_pwr[r_active]),
    .o_nxt (w_pwr_nxt)
  );

  tank_axis_adj #(.ACCEL_FRAMES(ACCEL_FRAMES)) u_ang_adj (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adj_en),
    .i_clr (~w_in_aim),
    .i_inc (w_right),
    .i_dec (w_left),
    .i_cur (r_ang[r_active]),
    .o_nxt (w_ang_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_a_q     <= 1'b0;
    end else if (frame_tick) begin
      r_start_q <= w_start;
      r_a_q     <= w_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_active   <= 1'b0;
      r_winner   <= 1'b0;
      r_pwr[0]   <= PWR_INIT;
      r_pwr[1]   <= PWR_INIT;
      r_ang[0]   <= ANG_INIT;
      r_ang[1]   <= ANG_INIT;
      r_score[0] <= '0;
      r_score[1] <= '0;
      r_flight   <= '0;
      r_hits     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state    <= S_AIM;
            r_active   <= 1'b0;
            r_winner   <= 1'b0;
            r_pwr[0]   <= PWR_INIT;
            r_pwr[1]   <= PWR_INIT;
            r_ang[0]   <= ANG_INIT;
            r_ang[1]   <= ANG_INIT;
            r_score[0] <= '0;
            r_score[1] <= '0;
          end
        end
        S_AIM: begin
          if (frame_tick) begin
            if (w_a_edge) begin
              r_state <= S_FIRE;
            end else begin
              r_pwr[r_active] <= w_pwr_nxt;
              r_ang[r_active] <= w_ang_nxt;
            end
          end
        end
        S_FIRE: begin
          r_flight <= '0;
          r_state  <= S_FLIGHT;
        end
        S_FLIGHT: begin
          if (proj_done) begin
            r_hits  <= proj_hit;
            r_state <= S_RESOLVE;
          end else if (frame_tick) begin
            if (r_flight == TO_LAST) begin
              r_hits  <= '0;
              r_state <= S_RESOLVE;
            end else begin
              r_flight <= r_flight + 8'd1;
            end
          end
        end
        S_RESOLVE: begin
          r_state <= S_SWAP;
          if (w_opp_hit && !w_self_hit) begin
            r_score[r_active] <= w_act_inc;
            if (w_act_inc == WIN) begin
              r_state  <= S_GAMEOVER;
              r_winner <= r_active;
            end
          end else if (w_self_hit && !w_opp_hit) begin
            r_score[w_opp] <= w_opp_inc;
            if (w_opp_inc == WIN) begin
              r_state  <= S_GAMEOVER;
              r_winner <= w_opp;
            end
          end
        end
        S_SWAP: begin
          r_active <= ~r_active;
          r_state  <= S_AIM;
        end
        S_GAMEOVER: begin
          if (w_start_edge)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered strobe: high in the first FLIGHT cycle, two clocks after the fire tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fire <= 1'b0;
    else
      r_fire <= (r_state == S_FIRE);
  end

  assign power         = r_pwr[r_active];
  assign angle         = r_ang[r_active];
  assign active_player = r_active;
  assign fire          = r_fire;
  assign game_state    = r_state;
  assign score0        = r_score[0];
  assign score1        = r_score[1];
  assign winner        = r_winner;

endmodule

// File: tb/tb_tank_turn_ctrl.sv
// Self-checking bench for tank_turn_ctrl: vector table, directed turn sequences
// and randomized aiming against a frame-level model of the game rules.
module tb_tank_turn_ctrl;
  import tank_pkg::*;

  localparam int WIN = 3;
  localparam int TMO = 240;
  localparam int ACC = 16;
`ifdef TANK_ACCEL_EN
  localparam int EXP_HOLD20 = 96;
`else
  localparam int EXP_HOLD20 = 84;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pad_present = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_a = 1'b0, btn_start = 1'b0;
  logic       proj_done = 1'b0;
  logic [1:0] proj_hit = 2'b00;
  logic [7:0] power, angle;
  logic       active_player, fire, winner;
  logic [2:0] game_state;
  logic [3:0] score0, score1;

  tank_turn_ctrl #(
    .WIN_SCORE(WIN), .FLIGHT_TIMEOUT(TMO), .PWR_INIT(8'd128),
    .ANG_INIT(8'd64), .ACCEL_FRAMES(ACC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pad_present(pad_present),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_a(btn_a), .btn_start(btn_start), .proj_done(proj_done), .proj_hit(proj_hit),
    .power(power), .angle(angle), .active_player(active_player), .fire(fire),
    .game_state(game_state), .score0(score0), .score1(score1), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_fire = 0;
  // Model: per-player settings and scores; signed hold = consecutive frames (+inc / -dec).
  int m_pwr[2], m_ang[2], m_sc[2];
  int m_hp, m_ha, m_act, m_win;
  bit m_over;

  always @(negedge clk) if (fire === 1'b1) n_fire++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void axis_model(inout int val, inout int hold, input bit inc, input bit dec);
    int step;
    if (inc == dec) begin
      hold = 0;
      return;
    end
    if (inc) hold = (hold > 0) ? hold + 1 : 1;
    else     hold = (hold < 0) ? hold - 1 : -1;
    step = 1;
`ifdef TANK_ACCEL_EN
    if (hold > ACC || hold < -ACC) step = 4;
`endif
    val = inc ? val + step : val - step;
    if (val > 255) val = 255;
    if (val < 0)   val = 0;
  endfunction

  task automatic model_new_game();
    m_pwr[0] = 128; m_pwr[1] = 128; m_ang[0] = 64; m_ang[1] = 64;
    m_sc[0] = 0; m_sc[1] = 0; m_act = 0; m_hp = 0; m_ha = 0;
    m_over = 1'b0; m_win = 0;
  endtask

  task automatic ftick();
    frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic aim_tick(input bit up, input bit dn, input bit lf, input bit rt,
                          input bit pad, input string nm);
    int p, a;
    btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt; pad_present = pad;
    frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
    p = m_pwr[m_act]; a = m_ang[m_act];
    axis_model(p, m_hp, up & pad, dn & pad);
    axis_model(a, m_ha, rt & pad, lf & pad);
    m_pwr[m_act] = p; m_ang[m_act] = a;
    chk({nm, "_pwr"}, power, m_pwr[m_act]);
    chk({nm, "_ang"}, angle, m_ang[m_act]);
    @(posedge clk); #1;
  endtask

  task automatic release_all();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_a = 0; pad_present = 1;
  endtask

  task automatic shoot(input bit hold_up);
    release_all();
    aim_tick(0, 0, 0, 0, 1, "pre_fire");
    btn_a = 1'b1; btn_up = hold_up;
    frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
    m_hp = 0; m_ha = 0;
    chk("fire_state", game_state, S_FIRE);
    chk("fire_early", fire, 0);
    chk("fire_pwr_held", power, m_pwr[m_act]);
    @(posedge clk); #1;
    chk("fire_pulse", fire, 1);
    chk("fire_pwr", power, m_pwr[m_act]);
    chk("fire_ang", angle, m_ang[m_act]);
    chk("flight_state", game_state, S_FLIGHT);
    @(posedge clk); #1;
    chk("fire_single", fire, 0);
    btn_a = 1'b0; btn_up = 1'b0;
  endtask

  task automatic flight_ticks(input int n);
    for (int i = 0; i < n; i++) ftick();
    chk("flight_wait", game_state, S_FLIGHT);
  endtask

  task automatic resolve(input bit done, input bit tk, input logic [1:0] hits, input string nm);
    logic [1:0] eff;
    int opp;
    proj_done = done; proj_hit = hits; frame_tick = tk;
    @(posedge clk); #1;
    proj_done = 1'b0; proj_hit = 2'b00; frame_tick = 1'b0;
    chk({nm, "_resolve"}, game_state, S_RESOLVE);
    @(posedge clk); #1; @(posedge clk); #1;
    eff = done ? hits : 2'b00;
    opp = 1 - m_act;
    if (eff[opp] && !eff[m_act])      m_sc[m_act]++;
    else if (eff[m_act] && !eff[opp]) m_sc[opp]++;
    if (m_sc[0] == WIN || m_sc[1] == WIN) begin
      m_over = 1'b1;
      m_win  = (m_sc[0] == WIN) ? 0 : 1;
    end else begin
      m_act = opp;
    end
    chk({nm, "_score0"}, score0, m_sc[0]);
    chk({nm, "_score1"}, score1, m_sc[1]);
    chk({nm, "_active"}, active_player, m_act);
    chk({nm, "_state"}, game_state, m_over ? S_GAMEOVER : S_AIM);
    if (m_over) chk({nm, "_winner"}, winner, m_win);
    chk({nm, "_pwr"}, power, m_pwr[m_act]);
    chk({nm, "_ang"}, angle, m_ang[m_act]);
  endtask

  typedef struct {
    bit pad, up, dn, lf, rt;
    int ep, ea;
  } vec_t;

  vec_t vt[11];

  initial begin
    int n0, loops;
    bit prev_up;
    logic [3:0] rb;
    bit rpad;

    vt[0]  = '{1, 1, 0, 0, 0, 129, 64};
    vt[1]  = '{1, 1, 0, 0, 0, 130, 64};
    vt[2]  = '{1, 0, 1, 0, 0, 129, 64};
    vt[3]  = '{1, 1, 1, 0, 0, 129, 64};
    vt[4]  = '{1, 0, 0, 1, 0, 129, 63};
    vt[5]  = '{1, 0, 0, 1, 1, 129, 63};
    vt[6]  = '{1, 0, 0, 0, 1, 129, 64};
    vt[7]  = '{0, 1, 0, 1, 0, 129, 64};
    vt[8]  = '{1, 0, 0, 0, 0, 129, 64};
    vt[9]  = '{1, 1, 0, 1, 0, 130, 63};
    vt[10] = '{1, 0, 1, 0, 1, 129, 64};

    model_new_game();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", game_state, S_IDLE);
    chk("rst_power", power, 128);
    chk("rst_angle", angle, 64);
    chk("rst_score0", score0, 0);
    chk("rst_score1", score1, 0);
    chk("rst_fire", fire, 0);
    chk("rst_active", active_player, 0);
    chk("rst_winner", winner, 0);
    rst_n = 1'b1;
    ftick();
    chk("idle_stays", game_state, S_IDLE);

    btn_start = 1'b1; ftick(); btn_start = 1'b0;
    chk("start_state", game_state, S_AIM);
    chk("start_power", power, 128);
    chk("start_angle", angle, 64);
    chk("start_active", active_player, 0);
    chk("start_score0", score0, 0);

    for (int i = 0; i < 11; i++) begin
      aim_tick(vt[i].up, vt[i].dn, vt[i].lf, vt[i].rt, vt[i].pad, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_pwr", i), power, vt[i].ep);
      chk($sformatf("vec%0d_tbl_ang", i), angle, vt[i].ea);
    end
    aim_tick(0, 0, 0, 0, 1, "gap");

    for (int i = 0; i < 20; i++) aim_tick(0, 0, 0, 1, 1, "hold_right");
    chk("hold_right20", angle, EXP_HOLD20);

    aim_tick(0, 0, 0, 0, 1, "gap2");
    prev_up = 1'b0;
    loops = 0;
    while (m_pwr[0] != 254 && loops < 400) begin
      if (m_pwr[0] < 240) prev_up = 1'b1;
      else                prev_up = !prev_up;
      aim_tick(prev_up, 0, 0, 0, 1, "to254");
      loops++;
    end
    chk("at254", power, 254);
    for (int i = 0; i < 3; i++) begin
      aim_tick(1, 0, 0, 0, 1, "sat_hi");
      chk("sat_hi_const", power, 255);
    end
    for (int i = 0; i < 5; i++) begin
      aim_tick(1, 1, 0, 0, 1, "both_held");
      chk("both_held_const", power, 255);
    end
    loops = 0;
    while (m_ang[0] != 0 && loops < 200) begin
      aim_tick(0, 0, 1, 0, 1, "to_zero");
      loops++;
    end
    for (int i = 0; i < 3; i++) begin
      aim_tick(0, 0, 1, 0, 1, "sat_lo");
      chk("sat_lo_const", angle, 0);
    end

    rb = 4'd0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
      rpad = ($urandom_range(0, 15) != 0);
      aim_tick(rb[0], rb[1], rb[2], rb[3], rpad, "rand");
    end

    shoot(1'b1);
    btn_up = 1; btn_right = 1; btn_a = 1;
    for (int i = 0; i < 5; i++) ftick();
    chk("flight_ign_pwr", power, m_pwr[0]);
    chk("flight_ign_ang", angle, m_ang[0]);
    chk("flight_ign_state", game_state, S_FLIGHT);
    release_all();
    resolve(1'b1, 1'b0, 2'b10, "hit_opp");
    chk("p1_init_pwr", power, 128);
    chk("p1_init_ang", angle, 64);

    proj_done = 1'b1; proj_hit = 2'b10; @(posedge clk); #1;
    proj_done = 1'b0; proj_hit = 2'b00; @(posedge clk); #1; @(posedge clk); #1;
    chk("stray_done_state", game_state, S_AIM);
    chk("stray_done_score0", score0, 1);
    chk("stray_done_score1", score1, 0);

    shoot(1'b0);
    flight_ticks(TMO - 1);
    resolve(1'b0, 1'b1, 2'b11, "timeout");

    shoot(1'b0);
    flight_ticks(TMO - 1);
    resolve(1'b1, 1'b1, 2'b01, "done_on_last");
    chk("done_on_last_s1", score1, 1);

    shoot(1'b0);
    resolve(1'b1, 1'b0, 2'b01, "p1_scores");
    shoot(1'b0);
    resolve(1'b1, 1'b0, 2'b11, "both_hit");
    shoot(1'b0);
    resolve(1'b1, 1'b0, 2'b01, "win");
    chk("win_state", game_state, S_GAMEOVER);
    chk("win_winner", winner, 1);
    chk("win_score1", score1, 3);

    n0 = n_fire;
    btn_a = 0; ftick();
    btn_a = 1; btn_up = 1; btn_right = 1; ftick(); ftick();
    repeat (3) @(posedge clk);
    #1;
    chk("go_pwr", power, m_pwr[m_act]);
    chk("go_ang", angle, m_ang[m_act]);
    chk("go_state", game_state, S_GAMEOVER);
    chk("go_nofire", n_fire, n0);
    chk("go_score1", score1, 3);
    release_all();
    btn_start = 0; ftick();
    btn_start = 1; ftick();
    chk("go_to_idle", game_state, S_IDLE);
    btn_start = 0; ftick();
    btn_start = 1; ftick();
    btn_start = 0;
    model_new_game();
    chk("restart_state", game_state, S_AIM);
    chk("restart_score0", score0, 0);
    chk("restart_score1", score1, 0);
    chk("restart_active", active_player, 0);
    chk("restart_pwr", power, 128);
    chk("restart_ang", angle, 64);

    shoot(1'b0);
    flight_ticks(3);
    n0 = n_fire;
    rst_n = 1'b0;
    #2;
    chk("rst_flight_state", game_state, S_IDLE);
    chk("rst_flight_fire", fire, 0);
    chk("rst_flight_pwr", power, 128);
    btn_start = 1; ftick(); ftick(); ftick();
    chk("rst_held_state", game_state, S_IDLE);
    rst_n = 1'b1;
    btn_start = 0; ftick(); ftick();
    chk("post_rst_state", game_state, S_IDLE);
    chk("post_rst_nofire", n_fire, n0);
    chk("post_rst_score0", score0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
